if_fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues single-outstanding requests to a variable-latency instruction memory. It delivers each fetched instruction with its PC+4 to IF/ID, and handles pipeline stalls and branch/jump redirects. Wrong-path responses are squashed, so IF/ID only ever sees correct-path instructions or NOP bubbles.

---
 rtl/if_fetch_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing single-outstanding imem fetches, with stall hold and redirect squash
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_out,
    output logic [31:0] PC_plus4_out,
    output logic        ins_valid
);
    typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, hold_ins_q, hold_ins_d;
    logic [31:0] pc_plus4, target_pc;

    assign pc_plus4  = pc_q + 32'd4;
    assign target_pc = {redirect_pc[31:2], 2'b00};

    // Outputs are combinational so IF/ID captures them on the same edge; reset forces defaults
    always_comb begin
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        ins_valid    = 1'b0;
        ins_out      = NOP_INS;
        PC_plus4_out = 32'd0;
        if (!reset) begin
            case (state_q)
                REQ:  imem_req = !redirect;
                WAIT: if (imem_ack && !redirect && !stall) begin
                    ins_valid    = 1'b1;
                    ins_out      = imem_rdata;
                    PC_plus4_out = pc_plus4;
                end
                HOLD: if (!redirect && !stall) begin
                    ins_valid    = 1'b1;
                    ins_out      = hold_ins_q;
                    PC_plus4_out = pc_plus4;
                end
                default: ;
            endcase
        end
    end

    // Next-state: redirect always wins; acks seen outside WAIT/DROP are protocol errors and ignored
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_ins_d = hold_ins_q;
        case (state_q)
            REQ: begin
                if (redirect) pc_d = target_pc;
                else state_d = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = imem_ack ? REQ : DROP;
                end else if (imem_ack && stall) begin
                    hold_ins_d = imem_rdata;
                    state_d    = HOLD;
                end else if (imem_ack) begin
                    pc_d    = pc_plus4;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (redirect) pc_d = target_pc;
                if (imem_ack) state_d = REQ;
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = REQ;
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            hold_ins_q <= NOP_INS;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_ins_q <= hold_ins_d;
        end
    end
endmodule
